// File: rtl/i2c_target_regbank_pkg.sv
// Shared types and sizes for the I2C target register bank.
package i2c_target_pkg;

  localparam int REG_COUNT = 16;
  localparam int PTR_W     = 4;
  localparam int FILT_LEN  = 3;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_target_regbank_if.sv
// Status bundle of the I2C target: protocol state, register pointer and filtered lines.
interface i2c_target_regbank_if;
  import i2c_target_pkg::*;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic             sda_low;
  logic             scl_f;
  logic             sda_f;

  modport master (output state, ptr, sda_low, scl_f, sda_f);
  modport slave  (input  state, ptr, sda_low, scl_f, sda_f);

endinterface

// File: rtl/i2c_target_regbank_line_filter.sv
// Bus line conditioner: 2-flop synchronizer plus, with GLITCH_FILTER_EN defined,
// a 3-sample stability filter that only follows the line after FILT_LEN equal samples.
module i2c_line_filter
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic filt
);

  // The idle bus level is high, so every stage resets to 1.
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], line};
  end

`ifdef GLITCH_FILTER_EN
  logic [FILT_LEN-1:0] hist;
  logic [FILT_LEN-1:0] hist_next;
  logic                filt_q;

  assign hist_next = {hist[FILT_LEN-2:0], sync[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '1;
      filt_q <= 1'b1;
    end else begin
      hist <= hist_next;
      if (&hist_next)      filt_q <= 1'b1;
      else if (~|hist_next) filt_q <= 1'b0;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync[1];
`endif

endmodule

// File: rtl/i2c_target_regbank.sv
// I2C target with a 16 x 8-bit register bank and auto-incrementing pointer; register 15
// is a read-only ID. Optional input glitch filtering via the GLITCH_FILTER_EN macro.
module i2c_target_regbank
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  inout  wire  SCL,
  inout  wire  SDA,
  i2c_target_regbank_if.master stat
);

  localparam logic [PTR_W-1:0] ID_REG   = PTR_W'(REG_COUNT - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'd7;
  localparam logic [2:0]       BIT_ONE  = 3'd1;

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t           state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             sda_low, sda_low_n;
  logic             ack_phase, ack_phase_n;
  logic             match, match_n;
  logic             rack, rack_n;
  logic             wr_en;
  logic [7:0]       byte_in;
  logic [7:0]       rd_byte;
  logic [7:0]       regs [REG_COUNT];

  i2c_line_filter u_scl_filt (.clk(clk), .rst_n(rst_n), .line(SCL), .filt(scl_f));
  i2c_line_filter u_sda_filt (.clk(clk), .rst_n(rst_n), .line(SDA), .filt(sda_f));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_in   = {shift[6:0], sda_f};
  assign rd_byte   = regs[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= BIT_LAST;
      shift     <= 8'h00;
      ptr       <= '0;
      sda_low   <= 1'b0;
      ack_phase <= 1'b0;
      match     <= 1'b0;
      rack      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      sda_low   <= sda_low_n;
      ack_phase <= ack_phase_n;
      match     <= match_n;
      rack      <= rack_n;
    end
  end

  // SDA only ever changes on a detected scl_f falling edge, so the target never forms START/STOP.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    ptr_n       = ptr;
    sda_low_n   = sda_low;
    ack_phase_n = ack_phase;
    match_n     = match;
    rack_n      = rack;
    wr_en       = 1'b0;

    if (start_det) begin
      state_n     = ADDR;
      bit_cnt_n   = BIT_LAST;
      sda_low_n   = 1'b0;
      ack_phase_n = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      sda_low_n = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt - BIT_ONE;
            if (bit_cnt == 3'd0) begin
              ack_phase_n = 1'b0;
              if (state == ADDR) begin
                state_n = ADDR_ACK;
                match_n = (byte_in[7:1] == DEV_ADDR);
              end else if (state == PTR) begin
                state_n = PTR_ACK;
                ptr_n   = byte_in[PTR_W-1:0];
              end else begin
                state_n = WDATA_ACK;
                wr_en   = (ptr != ID_REG);
                ptr_n   = ptr + PTR_ONE;
              end
            end
          end
        end
        // First fall drives the ACK slot, second fall (end of 9th clock) releases it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase_n = 1'b1;
              sda_low_n   = (state != ADDR_ACK) || match;
            end else begin
              ack_phase_n = 1'b0;
              sda_low_n   = 1'b0;
              bit_cnt_n   = BIT_LAST;
              if (state != ADDR_ACK) begin
                state_n = WDATA;
              end else if (!match) begin
                state_n = WAIT_STOP;
              end else if (shift[0]) begin
                state_n   = RDATA;
                shift_n   = rd_byte;
                ptr_n     = ptr + PTR_ONE;
                sda_low_n = ~rd_byte[7];
              end else begin
                state_n = PTR;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              state_n   = RACK;
              sda_low_n = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt - BIT_ONE;
              shift_n   = {shift[6:0], 1'b0};
              sda_low_n = ~shift[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) rack_n = ~sda_f;
          if (scl_fall) begin
            if (rack) begin
              state_n   = RDATA;
              bit_cnt_n = BIT_LAST;
              shift_n   = rd_byte;
              ptr_n     = ptr + PTR_ONE;
              sda_low_n = ~rd_byte[7];
            end else begin
              state_n   = WAIT_STOP;
              sda_low_n = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        regs[i] <= (i == REG_COUNT - 1) ? ID_VALUE : 8'h00;
    end else if (wr_en) begin
      regs[ptr] <= byte_in;
    end
  end

  assign SDA = sda_low ? 1'b0 : 1'bz;

  assign stat.state   = state;
  assign stat.ptr     = ptr;
  assign stat.sda_low = sda_low;
  assign stat.scl_f   = scl_f;
  assign stat.sda_f   = sda_f;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Bus-level bench: an open-drain master drives directed transactions while a separate
// bus monitor decodes every byte/ACK and checks it against the expectation queue.
module tb_i2c_target_regbank;
  import i2c_target_pkg::*;

  localparam int Q = 8;

  logic clk;
  logic rst_n;
  logic m_scl_low;
  logic m_sda_low;
  wire  SCL;
  wire  SDA;

  int checks;
  int failures;
  int low_cnt;
  int busy_cnt;

  logic [8:0] exp_q  [$];
  string      name_q [$];

  pullup (SCL);
  pullup (SDA);
  assign SCL = m_scl_low ? 1'b0 : 1'bz;
  assign SDA = m_sda_low ? 1'b0 : 1'bz;

  i2c_target_regbank_if stat_if ();

  i2c_target_regbank #(.DEV_ADDR(7'h48), .ID_VALUE(8'hA5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SCL  (SCL),
    .SDA  (SDA),
    .stat (stat_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stat_if.sda_low) low_cnt <= low_cnt + 1;
    if (stat_if.state != IDLE) busy_cnt <= busy_cnt + 1;
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endfunction

  // Bus monitor: START/STOP resync the bit count, the 9th rising SCL edge closes a byte.
  initial begin : monitor
    logic       scl_p, sda_p;
    int         bits;
    logic [7:0] byt;
    logic [8:0] exp;
    string      nm;
    scl_p = 1'b1; sda_p = 1'b1; bits = 0; byt = 8'h00;
    forever begin
      @(SCL or SDA or rst_n);
      if (!rst_n) begin
        bits = 0;
      end else if (SCL && scl_p && (SDA != sda_p)) begin
        bits = 0;
      end else if (SCL && !scl_p) begin
        if (bits < 8) begin
          byt  = {byt[6:0], SDA};
          bits = bits + 1;
        end else begin
          bits = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got 0x%02h ack=%0b required none", byt, !SDA);
          end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            check(nm, {23'd0, !SDA, byt}, {23'd0, exp});
          end
        end
      end
      scl_p = SCL;
      sda_p = SDA;
    end
  end

  task automatic clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(logic b);
    m_sda_low = ~b;
    clks(Q);
    m_scl_low = 1'b0;
    clks(2 * Q);
    m_scl_low = 1'b1;
    clks(1);
    m_sda_low = 1'b0;
    clks(Q - 1);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; clks(Q);
    m_scl_low = 1'b0; clks(Q);
    m_sda_low = 1'b1; clks(Q);
    m_scl_low = 1'b1; clks(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; clks(Q);
    m_scl_low = 1'b0; clks(Q);
    m_sda_low = 1'b0; clks(2 * Q);
  endtask

  task automatic send_bits(logic [7:0] b);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
  endtask

  // ack=1 means the target is expected to pull SDA low in the 9th slot.
  task automatic wr_byte(logic [7:0] b, logic ack, string name);
    exp_q.push_back({ack, b});
    name_q.push_back(name);
    send_bits(b);
    bus_bit(1'b1);
  endtask

  task automatic rd_byte(logic [7:0] exp, logic mack, string name);
    exp_q.push_back({mack, exp});
    name_q.push_back(name);
    repeat (8) bus_bit(1'b1);
    bus_bit(~mack);
  endtask

  initial begin : stimulus
    int l0;
    int b0;
    checks = 0; failures = 0; low_cnt = 0; busy_cnt = 0;
    m_scl_low = 1'b0; m_sda_low = 1'b0; rst_n = 1'b0;
    clks(5);
    rst_n = 1'b1;
    clks(2 * Q);
    check("reset_sda", {31'd0, SDA}, 32'd1);
    check("reset_ptr", 32'(stat_if.ptr), 32'd0);
    check("reset_state", 32'(stat_if.state), 32'(IDLE));

    // Plain write of 0x5A to register 3.
    bus_start();
    wr_byte(8'h90, 1'b1, "w_addr_ack");
    wr_byte(8'h03, 1'b1, "w_ptr_ack");
    wr_byte(8'h5A, 1'b1, "w_data_ack");
    bus_stop();
    check("write_ptr", 32'(stat_if.ptr), 32'd4);

    // Pointer set, repeated START, two-byte read.
    bus_start();
    wr_byte(8'h90, 1'b1, "r_addr_w_ack");
    wr_byte(8'h03, 1'b1, "r_ptr_ack");
    bus_start();
    wr_byte(8'h91, 1'b1, "r_addr_r_ack");
    rd_byte(8'h5A, 1'b1, "r_byte0");
    rd_byte(8'h00, 1'b0, "r_byte1");
    bus_stop();
    check("read_ptr", 32'(stat_if.ptr), 32'd5);
    check("read_sda_released", {31'd0, SDA}, 32'd1);

    // Foreign address: NACK and no SDA activity at all.
    l0 = low_cnt;
    bus_start();
    wr_byte(8'h92, 1'b0, "bad_addr_nack");
    wr_byte(8'h00, 1'b0, "bad_data_nack");
    bus_stop();
    check("bad_addr_no_drive", low_cnt - l0, 32'd0);
    check("bad_addr_ptr", 32'(stat_if.ptr), 32'd5);

    // Write to the ID register is acknowledged but discarded; pointer wraps.
    bus_start();
    wr_byte(8'h90, 1'b1, "id_addr_ack");
    wr_byte(8'h0F, 1'b1, "id_ptr_ack");
    wr_byte(8'h33, 1'b1, "id_data_ack");
    bus_stop();
    check("wrap_ptr", 32'(stat_if.ptr), 32'd0);

    bus_start();
    wr_byte(8'h90, 1'b1, "idr_addr_w_ack");
    wr_byte(8'h0F, 1'b1, "idr_ptr_ack");
    bus_start();
    wr_byte(8'h91, 1'b1, "idr_addr_r_ack");
    rd_byte(8'hA5, 1'b1, "idr_byte_id");
    rd_byte(8'h00, 1'b0, "idr_byte_wrap");
    bus_stop();
    check("idr_ptr", 32'(stat_if.ptr), 32'd1);

    // One-clock low pulse on SDA while the bus idles.
    l0 = low_cnt;
    b0 = busy_cnt;
    clks(Q);
    m_sda_low = 1'b1;
    clks(1);
    m_sda_low = 1'b0;
    clks(4 * Q);
`ifdef GLITCH_FILTER_EN
    check("glitch_no_start", {31'd0, busy_cnt != b0}, 32'd0);
`else
    check("glitch_start_seen", {31'd0, busy_cnt != b0}, 32'd1);
`endif
    check("glitch_no_drive", low_cnt - l0, 32'd0);
    check("glitch_state", 32'(stat_if.state), 32'(IDLE));

    // Reset while the target is acknowledging its address.
    bus_start();
    send_bits(8'h90);
    check("ack_driving", {31'd0, stat_if.sda_low}, 32'd1);
    check("ack_sda_low", {31'd0, SDA}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_sda_released", {31'd0, SDA}, 32'd1);
    clks(2);
    m_sda_low = 1'b0;
    m_scl_low = 1'b0;
    clks(Q);
    rst_n = 1'b1;
    clks(4 * Q);
    check("rst_state", 32'(stat_if.state), 32'(IDLE));
    check("rst_ptr", 32'(stat_if.ptr), 32'd0);

    bus_start();
    wr_byte(8'h90, 1'b1, "post_addr_w_ack");
    wr_byte(8'h03, 1'b1, "post_ptr3_ack");
    bus_start();
    wr_byte(8'h91, 1'b1, "post_addr_r_ack");
    rd_byte(8'h00, 1'b0, "post_reg3_cleared");
    bus_stop();

    bus_start();
    wr_byte(8'h90, 1'b1, "post2_addr_w_ack");
    wr_byte(8'h0F, 1'b1, "post2_ptr_ack");
    bus_start();
    wr_byte(8'h91, 1'b1, "post2_addr_r_ack");
    rd_byte(8'hA5, 1'b1, "post2_reg15");
    rd_byte(8'h00, 1'b0, "post2_reg0");
    bus_stop();

    clks(4 * Q);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
